// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Bundles the pipeline request/response handshake and the
//                single-port data RAM bus of the memory access unit.
//                  master - pipeline side (drives requests, sees responses)
//                  slave  - the access unit itself
//                  ram    - the data RAM (sees strobes, returns read data)
//  Signals     : req_valid/req_ready/req_op/req_addr/req_wdata,
//                resp_valid/resp_err/resp_rdata,
//                mem_en/mem_we/mem_addr/mem_wdata/mem_rdata
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport ram (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Multi-cycle data-memory access stage between the MEM
//                pipeline stage and a single-port synchronous data RAM.
//                Executes LW, SW, LB, LBU and SB with big-endian byte
//                numbering (addr[1:0]=00 is bits 31:24). SB is performed as
//                read-modify-write.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - mem_access_unit_if.slave (request, response, RAM)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mem_access_unit_if.slave    bus
);

    localparam logic [2:0] c_op_lw  = 3'b000;
    localparam logic [2:0] c_op_sw  = 3'b001;
    localparam logic [2:0] c_op_lb  = 3'b010;
    localparam logic [2:0] c_op_lbu = 3'b011;
    localparam logic [2:0] c_op_sb  = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_wbuf;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;

    logic              w_accept;
    logic              w_req_err;
    logic [7:0]        w_sel_byte;
    logic [31:0]       w_merged;
    logic [31:0]       w_load_result;

    // ------------------------------------------------------------------
    // Request decode: only word accesses need alignment; codes above SB
    // are illegal.
    // ------------------------------------------------------------------
    always_comb begin
        w_accept  = bus.req_valid && (r_state == S_IDLE);
        w_req_err = 1'b0;
        if (bus.req_op > c_op_sb) begin
            w_req_err = 1'b1;
        end else if ((bus.req_op == c_op_lw || bus.req_op == c_op_sw) &&
                     (bus.req_addr[1:0] != 2'b00)) begin
            w_req_err = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Byte lane select and SB merge. Address offset 0 is the most
    // significant byte of the word.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_byte = 8'h00;
        w_merged   = bus.mem_rdata;
        case (r_addr[1:0])
            2'b00: begin
                w_sel_byte      = bus.mem_rdata[31:24];
                w_merged[31:24] = r_wdata[7:0];
            end
            2'b01: begin
                w_sel_byte      = bus.mem_rdata[23:16];
                w_merged[23:16] = r_wdata[7:0];
            end
            2'b10: begin
                w_sel_byte      = bus.mem_rdata[15:8];
                w_merged[15:8]  = r_wdata[7:0];
            end
            default: begin
                w_sel_byte      = bus.mem_rdata[7:0];
                w_merged[7:0]   = r_wdata[7:0];
            end
        endcase
    end

    always_comb begin
        w_load_result = 32'h0;
        case (r_op)
            c_op_lw:  w_load_result = bus.mem_rdata;
            c_op_lb:  w_load_result = {{24{w_sel_byte[7]}}, w_sel_byte};
            c_op_lbu: w_load_result = {24'h0, w_sel_byte};
            default:  w_load_result = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        w_state_next = S_RESP;
                    end else if (bus.req_op == c_op_sw) begin
                        w_state_next = S_WRITE;
                    end else begin
                        w_state_next = S_READ;
                    end
                end
            end
            S_READ:  w_state_next = S_WAIT;
            S_WAIT:  w_state_next = (r_op == c_op_sb) ? S_WRITE : S_RESP;
            S_WRITE: w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= 3'b000;
            r_addr       <= '0;
            r_wdata      <= 32'h0;
            r_wbuf       <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_op    <= bus.req_op;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end

            if (r_state == S_WAIT && r_op == c_op_sb) begin
                r_wbuf <= w_merged;
            end

            // Response flags are registered so they are high exactly in RESP.
            // An error is only ever detected at accept time, and that is the
            // only path from IDLE straight into RESP.
            r_resp_valid <= (w_state_next == S_RESP);
            r_resp_err   <= w_accept && w_req_err;

            // Loads reach RESP from WAIT; stores and errors report zero.
            // Between responses the last value is held.
            if (w_state_next == S_RESP) begin
                r_resp_rdata <= (r_state == S_WAIT) ? w_load_result : 32'h0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The RAM strobes decode the state directly so an
    // asynchronous reset removes them without waiting for a clock edge.
    // ------------------------------------------------------------------
    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.mem_en     = (r_state == S_READ) || (r_state == S_WRITE);
    assign bus.mem_we     = (r_state == S_WRITE);
    assign bus.mem_addr   = r_addr[ADDR_W-1:2];
    assign bus.mem_wdata  = (r_op == c_op_sb) ? r_wbuf : r_wdata;

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multi-cycle data-memory access stage between the MEM pipeline stage and a single-port synchronous data RAM.
- Executes LW, SW, LB, LBU and SB. Byte accesses are big-endian: addr[1:0]=00 selects bits 31:24 and 11 selects bits 7:0.
- SB is a read-modify-write: read the word, merge the byte, write the word back.
- The pipeline stalls while req_ready is low.

Parameters:
- ADDR_W, 32, request byte-address width; the memory word address is ADDR_W-2 bits.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  access request.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_op  in  3  000 LW, 001 SW, 010 LB, 011 LBU, 100 SB; all other codes are illegal.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; SB uses [7:0].
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid; set for misaligned LW/SW or an illegal op.
- resp_rdata  out  32  load result; holds until the next response.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable, valid only with mem_en.
- mem_addr  out  ADDR_W-2  word address = latched addr[ADDR_W-1:2].
- mem_wdata  out  32  write word.
- mem_rdata  in  32  read data, valid the cycle after a read strobe.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE, so req_ready=1.
  - resp_valid, resp_err, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata and all internal registers = 0.
  - Reset mid-operation abandons the access immediately. mem_en drops without waiting for the clock, and no pending SB write is issued.
- Accept in IDLE: latch op, addr, wdata.
  - Misaligned LW/SW (addr[1:0]!=00) or illegal op -> RESP with err=1.
  - SW -> WRITE.
  - LW, LB, LBU, SB -> READ.
- READ: mem_en=1, mem_we=0, mem_addr=latched word address -> WAIT.
- WAIT: sample mem_rdata. Byte lane = 3 - addr[1:0] counted from LSB.
  - LW: result = mem_rdata.
  - LB: result = sign-extended selected byte.
  - LBU: result = zero-extended selected byte.
  - Loads -> RESP.
  - SB: merge wdata[7:0] into the selected lane, leaving the other three bytes unchanged. Store the word in the write buffer -> WRITE.
- WRITE: mem_en=1, mem_we=1, mem_wdata = write buffer (SB) or latched wdata (SW) -> RESP.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - resp_err=err flag.
  - resp_rdata=result for loads; 0 for stores and errors.
  - Next state is IDLE.
- Latency, with the accept cycle as T:
  - resp_valid at T+3 for LW/LB/LBU.
  - resp_valid at T+2 for SW.
  - resp_valid at T+4 for SB.
  - resp_valid at T+1 for error, with no mem_en at any point.
- mem_en is 0 in IDLE and RESP. mem_we is never high without mem_en.
- req_valid outside IDLE is ignored and causes no state change. The earliest next accept is the cycle after RESP, i.e. back-to-back throughput is one request per latency+1 cycles.
- resp_valid and resp_err are registered outputs that are low outside the RESP cycle. resp_rdata retains its last value.
- Misalignment is checked only for LW/SW; LB/LBU/SB accept any byte address.

Test Plan:
- Byte loads: RAM word 0x40 = 0x8A223344.
  - LB 0x100 -> resp_rdata 0xFFFFFF8A at T+3.
  - LBU 0x100 -> 0x0000008A.
  - LB 0x103 -> 0x00000044.
  - Single mem_en read pulse at T+1 with mem_addr 0x40.
- SB: RAM word 0x40 = 0x11223344; SB 0x101 with wdata 0x000000AB.
  - Read at T+1.
  - Write at T+3 with mem_wdata 0x11AB3344.
  - resp_valid at T+4.
  - A following LW 0x100 returns 0x11AB3344.
- SW and misalignment:
  - SW 0x104 with 0xDEADBEEF -> write at T+1 to word 0x41; resp at T+2 with resp_err=0.
  - SW 0x106 -> resp_err=1 at T+1, mem_en never high.
  - req_op 111 -> resp_err=1 at T+1, mem_en never high.
- Reset mid-SB: assert rst_n=0 during WAIT.
  - Outputs go to 0 and req_ready goes to 1 asynchronously.
  - No write occurs after release; the RAM word is unchanged.
- Back-to-back: req_valid held high with LW 0x100 then LB 0x103.
  - Second request is not accepted until the cycle after the first resp_valid.
  - Exactly two resp_valid pulses.
  - No request is dropped or duplicated.
